// File: rtl/data_ram_ctrl_if.sv
// Control-unit side handshake bundle for the data RAM controller.
// master = control unit, slave = data_ram_ctrl.
interface data_ram_ctrl_if #(
   parameter int ADDRESS_BUS_WIDTH = 10,
   parameter int DATA_BUS_WIDTH    = 64,
   parameter int LEN_WIDTH         = 4
);
   logic                         req_valid;
   logic                         req_ready;
   logic                         req_write;
   logic [ADDRESS_BUS_WIDTH-1:0] req_addr;
   logic [LEN_WIDTH-1:0]         req_len;
   logic                         wr_valid;
   logic                         wr_ready;
   logic [DATA_BUS_WIDTH-1:0]    wr_data;
   logic                         rd_valid;
   logic [DATA_BUS_WIDTH-1:0]    rd_data;
   logic                         done;
   logic                         err;

   modport master (
      output req_valid, req_write, req_addr, req_len,
      output wr_valid, wr_data,
      input  req_ready, wr_ready, rd_valid, rd_data,
      input  done, err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len,
      input  wr_valid, wr_data,
      output req_ready, wr_ready, rd_valid, rd_data,
      output done, err
   );
endinterface

// File: rtl/data_ram_ctrl.sv
// Data RAM initiator: single/burst load-store requests from the control
// unit are turned into RAM chip-select/read/write cycles.
module data_ram_ctrl #(
   parameter int ADDRESS_BUS_WIDTH  = 10,
   parameter int DATA_BUS_WIDTH     = 64,
   parameter int NUM_DATA_ADDRESSES = 512,
   parameter int LEN_WIDTH          = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   data_ram_ctrl_if.slave               cu,
   output logic                         mem_cs,
   output logic                         mem_read,
   output logic                         mem_write,
   output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
   output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
   input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data
);
   localparam int AW = ADDRESS_BUS_WIDTH;
   localparam int DW = DATA_BUS_WIDTH;
   localparam int LW = LEN_WIDTH;
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(NUM_DATA_ADDRESSES - 1);

   typedef enum logic [2:0] {
      IDLE, RD, RD_DRAIN, WR, FINISH
   } state_t;

   state_t         state;
   logic [LW-1:0]  len_r;
   logic [LW-1:0]  cnt;
   logic [AW-1:0]  addr_r;
   logic           wr_all;
   logic           iss_d1;
   logic           last_d1;
   logic           req_ready;
   logic           rd_valid;
   logic [DW-1:0]  rd_data;
   logic           done;
   logic           err;
   logic [AW:0]    end_addr;
   logic           oor;
   logic           accept;
   logic           wr_ready;

   // End address is formed one bit wider so a burst can never wrap.
   assign end_addr = {1'b0, cu.req_addr}
                   + {{(AW+1-LW){1'b0}}, cu.req_len};
   assign oor      = end_addr > LAST_ADDR;
   assign accept   = cu.req_valid & req_ready;
   assign wr_ready = (state == WR) & ~wr_all;

   assign cu.req_ready = req_ready;
   assign cu.wr_ready  = wr_ready;
   assign cu.rd_valid  = rd_valid;
   assign cu.rd_data   = rd_data;
   assign cu.done      = done;
   assign cu.err       = err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         len_r          <= '0;
         cnt            <= '0;
         addr_r         <= '0;
         wr_all         <= 1'b0;
         iss_d1         <= 1'b0;
         last_d1        <= 1'b0;
         req_ready      <= 1'b0;
         rd_valid       <= 1'b0;
         rd_data        <= '0;
         done           <= 1'b0;
         err            <= 1'b0;
         mem_cs         <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         iss_d1   <= 1'b0;
         last_d1  <= 1'b0;
         rd_valid <= iss_d1;
         // RAM output is only trusted the cycle after an issue.
         if (iss_d1)
            rd_data <= mem_read_data;
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  len_r     <= cu.req_len;
                  cnt       <= '0;
                  addr_r    <= cu.req_addr;
                  wr_all    <= 1'b0;
                  if (oor) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (cu.req_write) begin
                     state <= WR;
                  end else begin
                     state       <= RD;
                     mem_cs      <= 1'b1;
                     mem_read    <= 1'b1;
                     mem_address <= cu.req_addr;
                  end
               end
            end
            RD: begin
               iss_d1 <= 1'b1;
               if (cnt == len_r) begin
                  last_d1  <= 1'b1;
                  state    <= RD_DRAIN;
                  mem_cs   <= 1'b0;
                  mem_read <= 1'b0;
               end else begin
                  cnt         <= cnt + LW'(1);
                  mem_address <= mem_address + AW'(1);
               end
            end
            RD_DRAIN: begin
               if (last_d1) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end
            end
            WR: begin
               if (wr_all) begin
                  mem_cs    <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= FINISH;
                  done      <= 1'b1;
               end else if (cu.wr_valid) begin
                  mem_cs         <= 1'b1;
                  mem_write      <= 1'b1;
                  mem_address    <= addr_r;
                  mem_write_data <= cu.wr_data;
                  addr_r         <= addr_r + AW'(1);
                  cnt            <= cnt + LW'(1);
                  if (cnt == len_r)
                     wr_all <= 1'b1;
               end else begin
                  mem_cs    <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            FINISH: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Initiator-side controller for the data RAM: the processor control unit hands it a single or burst load/store request over a valid/ready handshake.
- It drives the RAM chip-select, read, write, address and write-data pins, and captures the RAM's registered read data.
- Returns read words and a completion pulse to the control unit.
- Sits between the multicycle control FSM/datapath and the data memory.

Parameters:
ADDRESS_BUS_WIDTH, 10, width of RAM word address
DATA_BUS_WIDTH, 64, width of data word
NUM_DATA_ADDRESSES, 512, number of valid RAM words (legal addresses 0..511)
LEN_WIDTH, 4, burst length field width (beats = req_len+1, max 16)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller idle, request accepted on req_valid&req_ready at posedge
req_write  input  1  1 = store burst, 0 = load burst
req_addr  input  ADDRESS_BUS_WIDTH  base word address
req_len  input  LEN_WIDTH  beats minus one
wr_valid  input  1  store data word present
wr_ready  output  1  controller accepts wr_data this cycle
wr_data  input  DATA_BUS_WIDTH  store data word
rd_valid  output  1  rd_data holds a load word
rd_data  output  DATA_BUS_WIDTH  load data word
done  output  1  one-cycle pulse, request finished
err  output  1  one-cycle pulse with done, request rejected
mem_cs  output  1  RAM chip select
mem_read  output  1  RAM read enable
mem_write  output  1  RAM write enable
mem_address  output  ADDRESS_BUS_WIDTH  RAM address
mem_write_data  output  DATA_BUS_WIDTH  RAM write data
mem_read_data  input  DATA_BUS_WIDTH  RAM registered read data (high-Z while mem_cs low)

Behaviour:
- All outputs registered except wr_ready (= state is WR and beats remain).
- Reset (async, rst_n low): state IDLE; beat counter 0; all outputs 0, including req_ready and mem_* signals.
- req_ready goes 1 in the first cycle after rst_n deassertion.
- Mid-operation reset abandons the burst: no done; mem_cs drops immediately.
- States: IDLE, RD, RD_DRAIN, WR, FINISH.
- IDLE: req_ready=1; mem_cs=mem_read=mem_write=0.
- Range check on accept, computed at ADDRESS_BUS_WIDTH+1 bits: req_addr+req_len > NUM_DATA_ADDRESSES-1.
  - Failing requests go to FINISH with err=1.
  - No RAM access is made.
  - No address wrap-around is ever issued.
- RD:
  - One beat per cycle: mem_cs=1, mem_read=1, mem_address=base+i for i=0..len.
  - Last issue moves to RD_DRAIN.
- Read pipeline:
  - Issue in cycle T; RAM data valid in T+1; controller registers mem_read_data at end of T+1.
  - rd_data/rd_valid high in T+2.
  - Back-to-back beats give rd_valid high for len+1 consecutive cycles.
- RD_DRAIN: mem_cs=0; waits until the last rd_valid.
  - done pulses in the same cycle as the last rd_valid, then IDLE.
- mem_read_data is ignored outside the sampling cycles.
- WR:
  - On a posedge with wr_valid&wr_ready, the next cycle drives mem_cs=1, mem_write=1, mem_address=base+i, mem_write_data=wr_data.
  - While wr_valid is low: mem_cs=mem_write=0 (stall, no RAM access).
  - After the last beat accepted, go to FINISH.
- FINISH: done=1 for one cycle (err as decided); mem_* idle; then IDLE.
  - For a store, done coincides with the cycle after the last mem_write cycle.
- Accept to first mem_cs: 1 cycle. Single read accept to done: 3 cycles. Single write accept to done (wr_valid already high): 3 cycles.
- mem_read and mem_write are never both 1.
- req_valid while busy: ignored (req_ready=0).

Test Plan:
- Reset mid-burst: rst_n low during RD at beat 2 -> mem_cs=0 immediately, no done; req_ready=1 the cycle after release.
- Single read: addr=49, len=0; RAM preloaded mem[i]=i -> mem_cs/mem_read high 1 cycle at address 49; rd_valid with rd_data=49 and done both in the 3rd cycle after accept; req_ready back the next cycle.
- Burst read: addr=100, len=3 -> addresses 100..103 on consecutive cycles; rd_data 100,101,102,103 on 4 consecutive rd_valid cycles; done with the 4th.
- Burst write with stall: addr=10, len=2; wr_data 0xA,0xB,0xC with wr_valid low for 2 cycles after 0xA -> 3 mem_write cycles (addresses 10,11,12) with a 2-cycle gap; readback via burst read returns 0xA,0xB,0xC.
- Boundary: addr=509, len=2 accepted (addresses 509..511).
- Out of range: addr=510, len=3 -> no mem_cs, done=err=1 one cycle after accept.
